pll_lock_sequencer: RTL

Control-side companion to the clock-divider PLL wrapper: drives the PLL `reset`/`stdby` inputs and consumes its `extlock` output. It sequences power-up reset, qualifies lock over a stable window, releases a system reset, and detects lock loss or lock timeout with bounded retries. It also arbitrates a level-based standby request/acknowledge handshake. It sits beside the PLL instance and runs on the free-running board reference clock, never on a PLL output.

---
 rtl/pll_lock_sequencer_pkg.sv | 24 ++
 rtl/bit_sync.sv | 22 ++
 rtl/pll_lock_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and constants for the PLL lock sequencer slice.
// State encoding, default timing parameters and the counter width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        STBY,
        FAULT
    } seq_state_t;

    localparam int unsigned DEF_RST_PULSE_CYC    = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int unsigned DEF_MAX_RETRY        = 3;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Generic two-flop synchronizer for a single asynchronous level.
// Both stages clear to 0 on reset.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock/standby sequencer running on the free-running reference clock.
// Qualifies lock over a stable window, releases system reset, retries on timeout.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic                          refclk,
    input  logic                          reset_n,
    input  logic                          pll_extlock,
    input  logic                          stdby_req,
    output logic                          pll_reset,
    output logic                          pll_stdby,
    output logic                          sys_rst_n,
    output logic                          locked,
    output logic                          stdby_ack,
    output logic                          lock_lost,
    output logic                          fault,
    output logic [cnt_w(MAX_RETRY)-1:0]   retry_cnt
);

    localparam int unsigned RC_W = cnt_w(RST_PULSE_CYC);
    localparam int unsigned SC_W = cnt_w(LOCK_STABLE_CYC);
    localparam int unsigned TC_W = cnt_w(LOCK_TIMEOUT_CYC);
    localparam int unsigned RT_W = cnt_w(MAX_RETRY);

    localparam logic [RC_W-1:0] RST_LAST  = RC_W'(RST_PULSE_CYC - 1);
    localparam logic [SC_W-1:0] STAB_LAST = SC_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TC_W-1:0] TO_LAST   = TC_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRY);

    if ((LOCK_TIMEOUT_CYC <= LOCK_STABLE_CYC + 2) || (RST_PULSE_CYC < 2) ||
        (LOCK_STABLE_CYC < 1) || (MAX_RETRY < 1)) begin : g_cfg_check
        $error("pll_lock_sequencer: illegal timing parameter combination");
    end

    logic extlock_s;

    bit_sync u_extlock_sync (
        .clk   (refclk),
        .rst_n (reset_n),
        .d     (pll_extlock),
        .q     (extlock_s)
    );

    seq_state_t      state, state_d;
    logic [RC_W-1:0] rst_cnt, rst_cnt_d;
    logic [SC_W-1:0] stab_cnt, stab_cnt_d;
    logic [TC_W-1:0] to_cnt, to_cnt_d;
    logic [RT_W-1:0] retry_d, retry_inc;
    logic            timeout;
    seq_state_t      fail_state;
    logic            pll_reset_d, pll_stdby_d, sys_rst_n_d, locked_d;
    logic            stdby_ack_d, lock_lost_d, fault_d;

    always_comb begin
        state_d     = state;
        rst_cnt_d   = '0;
        stab_cnt_d  = '0;
        to_cnt_d    = '0;
        retry_d     = retry_cnt;
        lock_lost_d = 1'b0;
        timeout     = (to_cnt == TO_LAST);
        retry_inc   = (retry_cnt == RT_MAX) ? retry_cnt : retry_cnt + 1'b1;
        fail_state  = (retry_inc == RT_MAX) ? FAULT : RESET;

        // Completion is tested before timeout so a same-edge tie lands in RUN.
        unique case (state)
            RESET: begin
                if (rst_cnt == RST_LAST) state_d = WAIT_LOCK;
                else                     rst_cnt_d = rst_cnt + 1'b1;
            end
            WAIT_LOCK: begin
                to_cnt_d = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
                if (extlock_s && (LOCK_STABLE_CYC == 1)) begin
                    state_d = RUN;
                end else if (timeout) begin
                    retry_d = retry_inc;
                    state_d = fail_state;
                end else if (extlock_s) begin
                    state_d    = STABLE;
                    stab_cnt_d = SC_W'(1);
                end
            end
            STABLE: begin
                to_cnt_d = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;
                if (extlock_s && (stab_cnt == STAB_LAST)) begin
                    state_d = RUN;
                end else if (timeout) begin
                    retry_d = retry_inc;
                    state_d = fail_state;
                end else if (!extlock_s) begin
                    state_d = WAIT_LOCK;
                end else begin
                    stab_cnt_d = (stab_cnt == '1) ? stab_cnt : stab_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!extlock_s) begin
                    state_d     = RESET;
                    lock_lost_d = 1'b1;
                end else if (stdby_req) begin
                    state_d = STBY;
                end
            end
            STBY: begin
                if (!stdby_req) state_d = RESET;
            end
            FAULT: state_d = FAULT;
            default: state_d = RESET;
        endcase

        if ((state_d != WAIT_LOCK) && (state_d != STABLE)) to_cnt_d = '0;
        if (state_d == RUN) retry_d = '0;

        pll_reset_d = (state_d == RESET) || (state_d == FAULT);
        pll_stdby_d = (state_d == STBY);
        sys_rst_n_d = (state_d == RUN);
        locked_d    = (state_d == RUN);
        stdby_ack_d = (state == STBY) && (state_d == STBY);
        fault_d     = (state_d == FAULT);
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RESET;
            rst_cnt   <= '0;
            stab_cnt  <= '0;
            to_cnt    <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            pll_stdby <= 1'b0;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            stdby_ack <= 1'b0;
            lock_lost <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_d;
            rst_cnt   <= rst_cnt_d;
            stab_cnt  <= stab_cnt_d;
            to_cnt    <= to_cnt_d;
            retry_cnt <= retry_d;
            pll_reset <= pll_reset_d;
            pll_stdby <= pll_stdby_d;
            sys_rst_n <= sys_rst_n_d;
            locked    <= locked_d;
            stdby_ack <= stdby_ack_d;
            lock_lost <= lock_lost_d;
            fault     <= fault_d;
        end
    end

endmodule
